// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer. Dispatch allocates one entry per cycle at the
// tail, ALU writeback ports mark entries done, and up to RETIRE_WIDTH done
// entries leave from the head each cycle. The retire outputs are registered and
// feed the architectural map and the free pool.
module reorder_buffer #(
   parameter int DEPTH        = 16,
   parameter int IDX_WIDTH    = 4,
   parameter int PREG_WIDTH   = 6,
   parameter int AREG_WIDTH   = 5,
   parameter int NUM_WB       = 2,
   parameter int RETIRE_WIDTH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               alloc_valid,
   input  logic                               alloc_reg_write,
   input  logic [AREG_WIDTH-1:0]              alloc_areg,
   input  logic [PREG_WIDTH-1:0]              alloc_preg,
   input  logic [PREG_WIDTH-1:0]              alloc_old_preg,
   output logic                               alloc_ready,
   output logic [IDX_WIDTH-1:0]               alloc_idx,
   input  logic [NUM_WB-1:0]                  wb_valid,
   input  logic [NUM_WB*IDX_WIDTH-1:0]        wb_idx,
   output logic [RETIRE_WIDTH-1:0]            retire_valid,
   output logic [RETIRE_WIDTH*AREG_WIDTH-1:0] retire_areg,
   output logic [RETIRE_WIDTH*PREG_WIDTH-1:0] retire_preg,
   output logic [RETIRE_WIDTH-1:0]            retire_free_valid,
   output logic [RETIRE_WIDTH*PREG_WIDTH-1:0] retire_free_preg,
   output logic [IDX_WIDTH:0]                 count,
   output logic                               empty,
   output logic                               full
);

   localparam int CW = IDX_WIDTH + 1;

   // Pointers carry a wrap bit above the index so full and empty are distinct.
   logic [CW-1:0]         head, tail;
   logic [DEPTH-1:0]      valid_q, done_q, reg_write_q;
   logic [AREG_WIDTH-1:0] areg_q     [DEPTH];
   logic [PREG_WIDTH-1:0] preg_q     [DEPTH];
   logic [PREG_WIDTH-1:0] old_preg_q [DEPTH];

   logic                  alloc_fire;
   logic [RETIRE_WIDTH-1:0] ret_mask;
   logic [IDX_WIDTH-1:0]  ret_idx [RETIRE_WIDTH];
   logic [CW-1:0]         ret_n;
   logic                  ret_stop;

   assign count       = tail - head;
   assign empty       = (head == tail);
   assign full        = (head[IDX_WIDTH-1:0] == tail[IDX_WIDTH-1:0]) &&
                        (head[IDX_WIDTH] != tail[IDX_WIDTH]);
   assign alloc_ready = !full;
   assign alloc_idx   = tail[IDX_WIDTH-1:0];
   assign alloc_fire  = alloc_valid && !full;

   // Find the run of valid+done entries from head; the first gap stops retirement.
   always_comb begin
      ret_mask = '0;
      ret_n    = '0;
      ret_stop = 1'b0;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         ret_idx[k] = head[IDX_WIDTH-1:0] + IDX_WIDTH'(k);
         if (!ret_stop && valid_q[ret_idx[k]] && done_q[ret_idx[k]] && (CW'(k) < count)) begin
            ret_mask[k] = 1'b1;
            ret_n       = ret_n + 1'b1;
         end else begin
            ret_stop = 1'b1;
         end
      end
   end

   // Pointers, status bits and registered retire outputs; flush wins over everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head              <= '0;
         tail              <= '0;
         valid_q           <= '0;
         done_q            <= '0;
         retire_valid      <= '0;
         retire_areg       <= '0;
         retire_preg       <= '0;
         retire_free_valid <= '0;
         retire_free_preg  <= '0;
      end else if (flush) begin
         head              <= '0;
         tail              <= '0;
         valid_q           <= '0;
         done_q            <= '0;
         retire_valid      <= '0;
         retire_areg       <= '0;
         retire_preg       <= '0;
         retire_free_valid <= '0;
         retire_free_preg  <= '0;
      end else begin
         // Writebacks to empty slots are dropped; the allocating slot is never valid pre-edge.
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && valid_q[wb_idx[k*IDX_WIDTH +: IDX_WIDTH]])
               done_q[wb_idx[k*IDX_WIDTH +: IDX_WIDTH]] <= 1'b1;
         end
         for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (ret_mask[k]) begin
               valid_q[ret_idx[k]] <= 1'b0;
               done_q[ret_idx[k]]  <= 1'b0;
            end
            retire_valid[k]      <= ret_mask[k];
            retire_free_valid[k] <= ret_mask[k] && reg_write_q[ret_idx[k]];
            retire_areg[k*AREG_WIDTH +: AREG_WIDTH] <=
               ret_mask[k] ? areg_q[ret_idx[k]] : '0;
            retire_preg[k*PREG_WIDTH +: PREG_WIDTH] <=
               ret_mask[k] ? preg_q[ret_idx[k]] : '0;
            retire_free_preg[k*PREG_WIDTH +: PREG_WIDTH] <=
               ret_mask[k] ? old_preg_q[ret_idx[k]] : '0;
         end
         if (alloc_fire) begin
            valid_q[tail[IDX_WIDTH-1:0]] <= 1'b1;
            done_q[tail[IDX_WIDTH-1:0]]  <= 1'b0;
         end
         head <= head + ret_n;
         tail <= tail + CW'(alloc_fire);
      end
   end

   // Entry payload needs no reset; it is only read while the valid bit is set.
   always_ff @(posedge clk) begin
      if (alloc_fire && !flush) begin
         reg_write_q[tail[IDX_WIDTH-1:0]] <= alloc_reg_write;
         areg_q[tail[IDX_WIDTH-1:0]]      <= alloc_areg;
         preg_q[tail[IDX_WIDTH-1:0]]      <= alloc_preg;
         old_preg_q[tail[IDX_WIDTH-1:0]]  <= alloc_old_preg;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       alloc_valid;
   logic       alloc_reg_write;
   logic [4:0] alloc_areg;
   logic [5:0] alloc_preg;
   logic [5:0] alloc_old_preg;
   logic       alloc_ready;
   logic [3:0] alloc_idx;
   logic [1:0] wb_valid;
   logic [7:0] wb_idx;
   logic [1:0] retire_valid;
   logic [9:0] retire_areg;
   logic [11:0] retire_preg;
   logic [1:0] retire_free_valid;
   logic [11:0] retire_free_preg;
   logic [4:0] count;
   logic       empty;
   logic       full;

   int n_checks = 0;
   int n_pass   = 0;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
      .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
      .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx),
      .retire_valid(retire_valid), .retire_areg(retire_areg), .retire_preg(retire_preg),
      .retire_free_valid(retire_free_valid), .retire_free_preg(retire_free_preg),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic clear_in();
      flush = 0; alloc_valid = 0; alloc_reg_write = 0;
      alloc_areg = '0; alloc_preg = '0; alloc_old_preg = '0;
      wb_valid = '0; wb_idx = '0;
   endtask

   // One clock: apply inputs, take the edge, sample 1 time unit later, clear inputs.
   task automatic cyc(input logic av, input logic rw, input logic [4:0] ar,
                      input logic [5:0] pr, input logic [5:0] op,
                      input logic [1:0] wv, input logic [3:0] w0, input logic [3:0] w1,
                      input logic fl);
      alloc_valid = av; alloc_reg_write = rw; alloc_areg = ar;
      alloc_preg = pr; alloc_old_preg = op;
      wb_valid = wv; wb_idx = {w1, w0}; flush = fl;
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_ready", alloc_ready, 1);
      chk("rst_idx", alloc_idx, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rv", retire_valid, 0);
      idle();
      chk("idle_rv", retire_valid, 0);

      // out-of-order completion, in-order retirement
      cyc(1, 1, 5'd1, 6'd10, 6'd33, 2'b00, 0, 0, 0);
      chk("a0_idx", alloc_idx, 1);
      cyc(1, 1, 5'd2, 6'd11, 6'd34, 2'b00, 0, 0, 0);
      cyc(1, 1, 5'd3, 6'd12, 6'd35, 2'b00, 0, 0, 0);
      chk("a3_count", count, 3);
      chk("a3_idx", alloc_idx, 3);
      cyc(0, 0, 0, 0, 0, 2'b01, 4'd2, 0, 0);
      chk("wb2_rv", retire_valid, 0);
      cyc(0, 0, 0, 0, 0, 2'b01, 4'd0, 0, 0);
      chk("wb0_rv", retire_valid, 0);
      cyc(0, 0, 0, 0, 0, 2'b01, 4'd1, 0, 0);
      chk("r0_rv", retire_valid, 2'b01);
      chk("r0_free0", retire_free_preg[5:0], 33);
      chk("r0_areg0", retire_areg[4:0], 1);
      chk("r0_fv", retire_free_valid, 2'b01);
      chk("r0_slot1", retire_free_preg[11:6], 0);
      chk("r0_count", count, 2);
      idle();
      chk("r12_rv", retire_valid, 2'b11);
      chk("r12_free0", retire_free_preg[5:0], 34);
      chk("r12_free1", retire_free_preg[11:6], 35);
      chk("r12_preg1", retire_preg[11:6], 12);
      chk("r12_count", count, 0);
      idle();
      chk("r12_after_rv", retire_valid, 0);

      // fill to full from index 0
      cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
      chk("fl0_idx", alloc_idx, 0);
      for (int i = 0; i < 16; i++)
         cyc(1, 1, 5'(i), 6'(i + 16), 6'(i + 32), 2'b00, 0, 0, 0);
      chk("full_count", count, 16);
      chk("full_full", full, 1);
      chk("full_ready", alloc_ready, 0);
      cyc(1, 1, 5'd31, 6'd63, 6'd63, 2'b00, 0, 0, 0);
      chk("full_drop_count", count, 16);
      cyc(1, 1, 5'd0, 6'd50, 6'd60, 2'b01, 4'd0, 0, 0);
      chk("full_wb_count", count, 16);
      chk("full_wb_rv", retire_valid, 0);
      cyc(1, 1, 5'd0, 6'd50, 6'd60, 2'b00, 0, 0, 0);
      chk("full_ret_rv", retire_valid, 2'b01);
      chk("full_ret_free", retire_free_preg[5:0], 32);
      chk("full_ret_count", count, 15);
      chk("full_ret_idx", alloc_idx, 0);
      chk("full_ret_ready", alloc_ready, 1);
      cyc(1, 1, 5'd0, 6'd50, 6'd60, 2'b00, 0, 0, 0);
      chk("wrap_count", count, 16);
      chk("wrap_full", full, 1);
      chk("wrap_idx", alloc_idx, 1);

      // five done entries from head (idx 1..5) retire 2,2,1
      cyc(0, 0, 0, 0, 0, 2'b11, 4'd1, 4'd2, 0);
      chk("b0_rv", retire_valid, 0);
      cyc(0, 0, 0, 0, 0, 2'b11, 4'd3, 4'd4, 0);
      chk("b1_rv", retire_valid, 2'b11);
      chk("b1_areg0", retire_areg[4:0], 1);
      chk("b1_areg1", retire_areg[9:5], 2);
      chk("b1_preg0", retire_preg[5:0], 17);
      chk("b1_preg1", retire_preg[11:6], 18);
      cyc(0, 0, 0, 0, 0, 2'b01, 4'd5, 0, 0);
      chk("b2_rv", retire_valid, 2'b11);
      chk("b2_free0", retire_free_preg[5:0], 35);
      chk("b2_free1", retire_free_preg[11:6], 36);
      idle();
      chk("b3_rv", retire_valid, 2'b01);
      chk("b3_areg0", retire_areg[4:0], 5);
      chk("b3_preg1", retire_preg[11:6], 0);
      chk("b3_count", count, 11);
      idle();
      chk("b4_rv", retire_valid, 0);

      // flush beats alloc, writeback and a pending retire
      cyc(0, 0, 0, 0, 0, 2'b11, 4'd6, 4'd7, 0);
      chk("pf_rv", retire_valid, 0);
      cyc(1, 1, 5'd9, 6'd9, 6'd9, 2'b11, 4'd8, 4'd9, 1);
      chk("fl_count", count, 0);
      chk("fl_empty", empty, 1);
      chk("fl_idx", alloc_idx, 0);
      chk("fl_rv", retire_valid, 0);
      idle();
      chk("fl_after_rv", retire_valid, 0);
      chk("fl_after_count", count, 0);

      // store: retires without freeing a register
      cyc(1, 0, 5'd7, 6'd9, 6'd8, 2'b00, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 2'b01, 4'd0, 0, 0);
      chk("st_wb_rv", retire_valid, 0);
      idle();
      chk("st_rv", retire_valid, 2'b01);
      chk("st_fv", retire_free_valid, 0);
      chk("st_areg", retire_areg[4:0], 7);
      chk("st_preg", retire_preg[5:0], 9);

      // async reset between edges
      cyc(1, 1, 5'd1, 6'd1, 6'd41, 2'b00, 0, 0, 0);
      cyc(1, 1, 5'd2, 6'd2, 6'd42, 2'b00, 0, 0, 0);
      cyc(1, 1, 5'd3, 6'd3, 6'd43, 2'b11, 4'd1, 4'd2, 0);
      idle();
      chk("ar_pre_rv", retire_valid, 2'b11);
      chk("ar_pre_count", count, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_rv", retire_valid, 0);
      chk("ar_free", retire_free_preg, 0);
      chk("ar_count", count, 0);
      chk("ar_idx", alloc_idx, 0);
      chk("ar_ready", alloc_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      chk("ar_post_count", count, 0);
      chk("ar_post_rv", retire_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
